// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD modulo counter with up/down, validated load and combinational terminal count
module bcd_mod_counter #(
   parameter int MAX_VAL = 59,
   parameter int MIN_VAL = 0,
   parameter int RST_VAL = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       dec,
   input  logic       ld,
   input  logic [3:0] ld_tens,
   input  logic [3:0] ld_ones,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       tc,
   output logic       ld_err
);
   localparam logic [3:0] MAX_T = 4'(MAX_VAL / 10);
   localparam logic [3:0] MAX_O = 4'(MAX_VAL % 10);
   localparam logic [3:0] MIN_T = 4'(MIN_VAL / 10);
   localparam logic [3:0] MIN_O = 4'(MIN_VAL % 10);
   localparam logic [3:0] RST_T = 4'(RST_VAL / 10);
   localparam logic [3:0] RST_O = 4'(RST_VAL % 10);
   if (MAX_VAL > 99 || MIN_VAL < 0 || MIN_VAL >= MAX_VAL || RST_VAL < MIN_VAL || RST_VAL > MAX_VAL) begin : g_bad_params
      $fatal(1, "bcd_mod_counter: illegal MAX_VAL/MIN_VAL/RST_VAL");
   end
   logic [3:0] tens_q, tens_d, ones_q, ones_d;
   logic       ld_err_q, ld_err_d;
   logic       at_max, at_min, ld_ok;
   int         ld_v;
   assign at_max = tens_q == MAX_T && ones_q == MAX_O;
   assign at_min = tens_q == MIN_T && ones_q == MIN_O;
   assign ld_v   = 10 * int'(ld_tens) + int'(ld_ones);
   assign ld_ok  = ld_tens <= 4'd9 && ld_ones <= 4'd9 && ld_v >= MIN_VAL && ld_v <= MAX_VAL;
   assign tc     = rst & en & ~ld & (dec ? at_min : at_max);
   assign tens   = tens_q;
   assign ones   = ones_q;
   assign ld_err = ld_err_q;
   // next digits: load beats count; each digit steps in BCD with carry/borrow and range wrap
   always_comb begin
      tens_d   = tens_q;
      ones_d   = ones_q;
      ld_err_d = 1'b0;
      if (ld) begin
         tens_d   = ld_ok ? ld_tens : tens_q;
         ones_d   = ld_ok ? ld_ones : ones_q;
         ld_err_d = ~ld_ok;
      end else if (en && !dec) begin
         tens_d = at_max ? MIN_T : (ones_q == 4'd9) ? tens_q + 4'd1 : tens_q;
         ones_d = at_max ? MIN_O : (ones_q == 4'd9) ? 4'd0 : ones_q + 4'd1;
      end else if (en) begin
         tens_d = at_min ? MAX_T : (ones_q == 4'd0) ? tens_q - 4'd1 : tens_q;
         ones_d = at_min ? MAX_O : (ones_q == 4'd0) ? 4'd9 : ones_q - 4'd1;
      end
   end
   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         tens_q   <= RST_T;
         ones_q   <= RST_O;
         ld_err_q <= 1'b0;
      end else begin
         tens_q   <= tens_d;
         ones_q   <= ones_d;
         ld_err_q <= ld_err_d;
      end
   end
endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb_bcd_mod_counter: directed checks of default, 0-23 down, 12 h, load, reset priority and three-stage cascade
module tb_bcd_mod_counter;
   logic clk = 1'b0;
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;

   logic r0 = 1'b0, e0 = 1'b0, d0 = 1'b0, l0 = 1'b0;
   logic [3:0] lt0 = 4'd0, lo0 = 4'd0, t0, o0;
   logic tc0, er0;
   bcd_mod_counter u0 (.clk(clk), .rst(r0), .en(e0), .dec(d0), .ld(l0), .ld_tens(lt0), .ld_ones(lo0),
                       .tens(t0), .ones(o0), .tc(tc0), .ld_err(er0));

   logic r1 = 1'b0, e1 = 1'b0, d1 = 1'b0;
   logic [3:0] t1, o1;
   logic tc1, er1;
   bcd_mod_counter #(.MAX_VAL(23)) u1 (.clk(clk), .rst(r1), .en(e1), .dec(d1), .ld(1'b0), .ld_tens(4'd0),
                       .ld_ones(4'd0), .tens(t1), .ones(o1), .tc(tc1), .ld_err(er1));

   logic r2 = 1'b0, e2 = 1'b0, d2 = 1'b0;
   logic [3:0] t2, o2;
   logic tc2, er2;
   bcd_mod_counter #(.MAX_VAL(12), .MIN_VAL(1), .RST_VAL(12)) u2 (.clk(clk), .rst(r2), .en(e2), .dec(d2),
                       .ld(1'b0), .ld_tens(4'd0), .ld_ones(4'd0), .tens(t2), .ones(o2), .tc(tc2), .ld_err(er2));

   logic rc = 1'b0, ec = 1'b0, lc = 1'b0;
   logic [3:0] lst = 4'd0, lso = 4'd0, lmt = 4'd0, lmo = 4'd0, lht = 4'd0, lho = 4'd0;
   logic [3:0] st, so, mt, mo, ht, ho;
   logic tcs, tcm, tch, ers, erm, erh;
   bcd_mod_counter us (.clk(clk), .rst(rc), .en(ec), .dec(1'b0), .ld(lc), .ld_tens(lst), .ld_ones(lso),
                       .tens(st), .ones(so), .tc(tcs), .ld_err(ers));
   bcd_mod_counter um (.clk(clk), .rst(rc), .en(tcs), .dec(1'b0), .ld(lc), .ld_tens(lmt), .ld_ones(lmo),
                       .tens(mt), .ones(mo), .tc(tcm), .ld_err(erm));
   bcd_mod_counter #(.MAX_VAL(23)) uh (.clk(clk), .rst(rc), .en(tcm), .dec(1'b0), .ld(lc), .ld_tens(lht),
                       .ld_ones(lho), .tens(ht), .ones(ho), .tc(tch), .ld_err(erh));

   task automatic step;
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset;
      e0 = 1'b1; l0 = 1'b1; lt0 = 4'd4; lo0 = 4'd5;
      #1;
      total++; if (tc0 !== 1'b0) begin bad++; $display("FAIL reset_tc got=%b want=0", tc0); end
      step();
      total++; if ({t0, o0, er0, tc0} !== {8'h00, 2'b00}) begin bad++; $display("FAIL reset_u0 got=%h%h err=%b tc=%b want=00 err=0 tc=0", t0, o0, er0, tc0); end
      total++; if ({t1, o1} !== 8'h00) begin bad++; $display("FAIL reset_u1 got=%h%h want=00", t1, o1); end
      total++; if ({t2, o2} !== 8'h12) begin bad++; $display("FAIL reset_u2 got=%h%h want=12", t2, o2); end
      e0 = 1'b0; l0 = 1'b0;
      r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;
      step();
      total++; if ({t0, o0} !== 8'h00) begin bad++; $display("FAIL reset_hold got=%h%h want=00", t0, o0); end
   endtask

   task automatic test_up_count;
      e0 = 1'b1; d0 = 1'b0;
      for (int i = 0; i < 60; i++) begin
         #1;
         total++;
         if (t0 !== 4'(i / 10) || o0 !== 4'(i % 10) || tc0 !== (i == 59) || er0 !== 1'b0) begin
            bad++;
            $display("FAIL up_count i=%0d got=%h%h tc=%b err=%b want tc=%b err=0", i, t0, o0, tc0, er0, i == 59);
         end
         step();
      end
      total++; if ({t0, o0} !== 8'h00) begin bad++; $display("FAIL up_wrap got=%h%h want=00", t0, o0); end
      e0 = 1'b0;
   endtask

   task automatic test_down_23;
      int v;
      v = 0;
      e1 = 1'b1; d1 = 1'b1;
      for (int i = 0; i < 26; i++) begin
         #1;
         total++;
         if (t1 !== 4'(v / 10) || o1 !== 4'(v % 10) || tc1 !== (v == 0)) begin
            bad++;
            $display("FAIL down_23 v=%0d got=%h%h tc=%b want tc=%b", v, t1, o1, tc1, v == 0);
         end
         step();
         v = (v == 0) ? 23 : v - 1;
      end
      e1 = 1'b0;
   endtask

   task automatic test_12h;
      e2 = 1'b1; d2 = 1'b0;
      #1;
      total++; if ({t2, o2, tc2} !== {8'h12, 1'b1}) begin bad++; $display("FAIL h12_top got=%h%h tc=%b want=12 tc=1", t2, o2, tc2); end
      step();
      total++; if ({t2, o2, tc2} !== {8'h01, 1'b0}) begin bad++; $display("FAIL h12_wrap_up got=%h%h tc=%b want=01 tc=0", t2, o2, tc2); end
      step();
      total++; if ({t2, o2} !== 8'h02) begin bad++; $display("FAIL h12_up got=%h%h want=02", t2, o2); end
      d2 = 1'b1;
      step();
      #1;
      total++; if ({t2, o2, tc2} !== {8'h01, 1'b1}) begin bad++; $display("FAIL h12_down got=%h%h tc=%b want=01 tc=1", t2, o2, tc2); end
      step();
      total++; if ({t2, o2, tc2} !== {8'h12, 1'b0}) begin bad++; $display("FAIL h12_wrap_down got=%h%h tc=%b want=12 tc=0", t2, o2, tc2); end
      d2 = 1'b0;
      #1;
      total++; if (tc2 !== 1'b1) begin bad++; $display("FAIL h12_dir_tc got=%b want=1", tc2); end
      step();
      total++; if ({t2, o2} !== 8'h01) begin bad++; $display("FAIL h12_dir_change got=%h%h want=01", t2, o2); end
      e2 = 1'b0;
      step();
      total++; if ({t2, o2} !== 8'h01) begin bad++; $display("FAIL h12_hold got=%h%h want=01", t2, o2); end
   endtask

   task automatic test_load;
      l0 = 1'b1; lt0 = 4'd4; lo0 = 4'd5;
      step();
      total++; if ({t0, o0, er0} !== {8'h45, 1'b0}) begin bad++; $display("FAIL load_ok got=%h%h err=%b want=45 err=0", t0, o0, er0); end
      lt0 = 4'd0; lo0 = 4'ha;
      step();
      total++; if ({t0, o0, er0} !== {8'h45, 1'b1}) begin bad++; $display("FAIL load_nonbcd got=%h%h err=%b want=45 err=1", t0, o0, er0); end
      l0 = 1'b0;
      step();
      total++; if ({t0, o0, er0} !== {8'h45, 1'b0}) begin bad++; $display("FAIL err_pulse got=%h%h err=%b want=45 err=0", t0, o0, er0); end
      l0 = 1'b1; lt0 = 4'd6; lo0 = 4'd0;
      step();
      total++; if ({t0, o0, er0} !== {8'h45, 1'b1}) begin bad++; $display("FAIL load_range got=%h%h err=%b want=45 err=1", t0, o0, er0); end
      lt0 = 4'd5; lo0 = 4'd9;
      step();
      total++; if ({t0, o0, er0} !== {8'h59, 1'b0}) begin bad++; $display("FAIL load_max got=%h%h err=%b want=59 err=0", t0, o0, er0); end
      e0 = 1'b1; lt0 = 4'd1; lo0 = 4'd2;
      #1;
      total++; if (tc0 !== 1'b0) begin bad++; $display("FAIL load_en_tc got=%b want=0", tc0); end
      step();
      total++; if ({t0, o0, er0} !== {8'h12, 1'b0}) begin bad++; $display("FAIL load_en got=%h%h err=%b want=12 err=0", t0, o0, er0); end
      e0 = 1'b0; l0 = 1'b0;
   endtask

   task automatic test_reset_priority;
      l0 = 1'b1; lt0 = 4'd3; lo0 = 4'd7;
      step();
      total++; if ({t0, o0} !== 8'h37) begin bad++; $display("FAIL rstp_setup got=%h%h want=37", t0, o0); end
      e0 = 1'b1; lt0 = 4'd5; lo0 = 4'd0; r0 = 1'b0;
      #1;
      total++; if (tc0 !== 1'b0) begin bad++; $display("FAIL rstp_tc got=%b want=0", tc0); end
      step();
      total++; if ({t0, o0, er0} !== {8'h00, 1'b0}) begin bad++; $display("FAIL rstp got=%h%h err=%b want=00 err=0", t0, o0, er0); end
      r0 = 1'b1; e0 = 1'b0; l0 = 1'b0;
   endtask

   task automatic test_cascade;
      rc = 1'b1; lc = 1'b1;
      lht = 4'd2; lho = 4'd3; lmt = 4'd5; lmo = 4'd9; lst = 4'd5; lso = 4'd8;
      step();
      total++; if ({ht, ho, mt, mo, st, so} !== 24'h235958) begin bad++; $display("FAIL casc_load got=%h%h:%h%h:%h%h want=23:59:58", ht, ho, mt, mo, st, so); end
      lc = 1'b0; ec = 1'b1;
      #1;
      total++; if ({tcs, tcm, tch} !== 3'b000) begin bad++; $display("FAIL casc_tc58 got=%b want=000", {tcs, tcm, tch}); end
      step();
      total++; if ({ht, ho, mt, mo, st, so} !== 24'h235959) begin bad++; $display("FAIL casc_59 got=%h%h:%h%h:%h%h want=23:59:59", ht, ho, mt, mo, st, so); end
      #1;
      total++; if ({tcs, tcm, tch} !== 3'b111) begin bad++; $display("FAIL casc_tc59 got=%b want=111", {tcs, tcm, tch}); end
      step();
      total++; if ({ht, ho, mt, mo, st, so} !== 24'h000000) begin bad++; $display("FAIL casc_wrap got=%h%h:%h%h:%h%h want=00:00:00", ht, ho, mt, mo, st, so); end
      ec = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         total++;
         if ({ht, ho, mt, mo, st, so} !== 24'h000000 || {tcs, tcm, tch} !== 3'b000) begin
            bad++;
            $display("FAIL casc_hold i=%0d got=%h%h:%h%h:%h%h tc=%b want=00:00:00 tc=000", i, ht, ho, mt, mo, st, so, {tcs, tcm, tch});
         end
      end
      total++; if ({ers, erm, erh} !== 3'b000) begin bad++; $display("FAIL casc_err got=%b want=000", {ers, erm, erh}); end
   endtask

   initial begin
      test_reset();
      test_up_count();
      test_down_23();
      test_12h();
      test_load();
      test_reset_priority();
      test_cascade();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
